pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL provide these parameters, one per line: name, default, meaning.
- INSTR_W, 32, instruction field width
- PC_W, 32, program-counter field width
- NOP_INSTR, 32'h0000_0013, instruction driven when no valid beat is held (low INSTR_W bits used)
- CNT_W, 16, stall-counter width
REQ-002 The block SHALL provide these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge
- reset, in, 1, asynchronous, active-low reset
- in_valid, in, 1, upstream beat present
- in_ready, out, 1, block can accept a beat
- in_instr, in, INSTR_W, upstream instruction
- in_pc, in, PC_W, upstream PC
- flush, in, 1, synchronous kill of all held beats
- out_valid, out, 1, downstream beat present
- out_ready, in, 1, downstream accepts the beat
- out_instr, out, INSTR_W, held instruction
- out_pc, out, PC_W, held PC
- occupancy, out, 2, number of held beats (0..2)
- stall_cnt, out, CNT_W, saturating count of stalled cycles

Function
REQ-003 All state SHALL update on the rising edge of clk only; there SHALL be no negedge logic.
REQ-004 Storage SHALL be a main register plus one skid register; states EMPTY (0 beats), FULL (main only), SKID (main and skid).
REQ-005 in_ready SHALL be a registered output, equal to 1 in EMPTY and FULL and 0 in SKID.
REQ-006 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-007 out_valid SHALL be 1 in FULL and SKID; out_instr/out_pc SHALL always come from the main register.
REQ-008 Latency SHALL be one cycle: a beat accepted in EMPTY at edge N is presented at out_* after edge N.
REQ-009 EMPTY SHALL go to FULL on an input transfer and otherwise stay EMPTY.
REQ-010 FULL SHALL stay FULL on both transfers (main loads input), go to EMPTY on output only, go to SKID on input only (beat goes to skid), and hold otherwise.
REQ-011 SKID SHALL go to FULL on an output transfer (skid moves to main) and otherwise hold. No input transfer is possible in SKID.
REQ-012 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated except by flush.
REQ-013 When flush=1 at an edge, the next state SHALL be EMPTY regardless of in_valid/out_ready, and any input transfer in that cycle SHALL be discarded; flush wins over all simultaneous events.
REQ-014 When out_valid=0, out_instr SHALL equal NOP_INSTR and out_pc SHALL equal 0.
REQ-015 occupancy SHALL equal 0/1/2 for EMPTY/FULL/SKID.
REQ-016 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, SHALL saturate at 2^CNT_W-1, and SHALL be unaffected by flush.
REQ-017 The skid register contents SHALL not be visible on any output.

Reset
REQ-018 While reset=0, regardless of clk: state=EMPTY, in_ready=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0, occupancy=0, stall_cnt=0, skid register=0.
REQ-019 On the first rising edge after reset deasserts, in_ready SHALL become 1; no transfer SHALL be accepted before then.
REQ-020 Reset asserted mid-operation SHALL discard all held beats immediately, with no clock edge required.

Verification
REQ-021 Stream: out_ready=1, in_valid=1, PCs 0x0,0x4,0x8 -> out_pc 0x0,0x4,0x8 one cycle later each; occupancy stays 1.
REQ-022 Backpressure: hold out_ready=0 and present 0x10,0x14,0x18 -> 0x10 in main, 0x14 in skid, in_ready=0, 0x18 held upstream; raise out_ready -> output order 0x10,0x14,0x18.
REQ-023 Flush in SKID with in_valid=1 -> next cycle out_valid=0, out_instr=0x00000013, out_pc=0, occupancy=0, in_ready=1, input beat discarded.
REQ-024 Stall counter with CNT_W=2: stall 5 cycles -> stall_cnt reads 1,2,3,3,3.
REQ-025 Async reset: drop reset between clock edges while in FULL -> out_valid=0 and occupancy=0 immediately; in_ready=1 only after the first edge following release.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid-buffered pipeline stage register with stall counter
// Registered in_ready; output always driven from the main register.
module pipe_stage_reg #(
    parameter int          INSTR_W   = 32,
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               in_xfer, out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        stall_d      = stall_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d      = ST_FULL;
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                end
            end
            ST_FULL: begin
                if (in_xfer && out_xfer) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    state_d      = ST_SKID;
                    skid_instr_d = in_instr;
                    skid_pc_d    = in_pc;
                end
            end
            ST_SKID: begin
                if (out_xfer) begin
                    state_d      = ST_FULL;
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // flush overrides every transition but leaves the stall counter alone
        if (flush) begin
            state_d = ST_EMPTY;
        end

        in_ready_d = (state_d != ST_SKID);

        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            in_ready_q   <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            in_ready_q   <= in_ready_d;
            stall_q      <= stall_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_instr = out_valid ? main_instr_q : INSTR_W'(NOP_INSTR);
    assign out_pc    = out_valid ? main_pc_q : '0;
    assign stall_cnt = stall_q;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_FULL: occupancy = 2'd1;
            ST_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench for pipe_stage_reg
// Reference model is a bounded FIFO of beats plus saturating stall counters.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] out_instr, out_pc, out_instr2, out_pc2;
    logic [1:0]  occupancy, occupancy2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int n_pass = 0;
    int n_total = 0;

    logic [63:0] q[$];
    bit          m_rdy;
    int          m_stall16, m_stall2;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    function automatic logic [31:0] exp_pc();
        return (q.size() > 0) ? q[0][31:0] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_instr();
        return (q.size() > 0) ? q[0][63:32] : 32'h0000_0013;
    endfunction

    // Advance one clock and move the reference model; returns at the next negedge.
    task automatic step();
        bit ix, ox;
        ix = in_valid && m_rdy;
        ox = (q.size() > 0) && out_ready;
        if (q.size() > 0 && !out_ready) begin
            if (m_stall16 < 65535) m_stall16++;
            if (m_stall2 < 3) m_stall2++;
        end
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back({in_instr, in_pc});
        end
        m_rdy = (q.size() < 2);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        q.delete(); m_rdy = 1'b0; m_stall16 = 0; m_stall2 = 0;
        #2 reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        q.delete(); m_rdy = 1'b0; m_stall16 = 0; m_stall2 = 0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0h expected 0", out_valid); else n_pass++;
        n_total++; if (out_instr !== 32'h13) $display("FAIL reset_out_instr: got %0h expected 13", out_instr); else n_pass++;
        n_total++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc: got %0h expected 0", out_pc); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d expected 0", occupancy); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0h expected 0", in_ready); else n_pass++;
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); else n_pass++;
        @(negedge clk);
        in_valid = 1'b1; in_pc = 32'h55; in_instr = 32'hAA; reset = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL release_in_ready_pre_edge: got %0h expected 0", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL release_no_accept: got %0h expected 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready_post_edge: got %0h expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] pcs[3];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = pcs[i]; in_instr = $urandom;
            step();
            n_total++; if (out_pc !== pcs[i]) $display("FAIL stream_pc%0d: got %0h expected %0h", i, out_pc, pcs[i]); else n_pass++;
            n_total++; if (out_instr !== exp_instr()) $display("FAIL stream_instr%0d: got %0h expected %0h", i, out_instr, exp_instr()); else n_pass++;
            n_total++; if (occupancy !== 2'd1) $display("FAIL stream_occ%0d: got %0d expected 1", i, occupancy); else n_pass++;
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] pcs[3];
        logic [31:0] seen[$];
        pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h18;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = pcs[i]; in_instr = $urandom;
            step();
        end
        n_total++; if (occupancy !== 2'd2) $display("FAIL bp_occ: got %0d expected 2", occupancy); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0h expected 0", in_ready); else n_pass++;
        n_total++; if (out_pc !== 32'h10) $display("FAIL bp_main_pc: got %0h expected 10", out_pc); else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bit took;
            if (out_valid && out_ready) seen.push_back(out_pc);
            took = in_valid && m_rdy;
            step();
            if (took) in_valid = 1'b0;
        end
        n_total++; if (seen.size() != 3) $display("FAIL bp_count: got %0d expected 3", seen.size()); else n_pass++;
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            n_total++; if (seen[i] !== pcs[i]) $display("FAIL bp_order%0d: got %0h expected %0h", i, seen[i], pcs[i]); else n_pass++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_pc = 32'h40 + 32'(i * 4); in_instr = $urandom;
            step();
        end
        n_total++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occ: got %0d expected 2", occupancy); else n_pass++;
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h99; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %0h expected 0", out_valid); else n_pass++;
        n_total++; if (out_instr !== 32'h13) $display("FAIL flush_out_instr: got %0h expected 13", out_instr); else n_pass++;
        n_total++; if (out_pc !== 32'h0) $display("FAIL flush_out_pc: got %0h expected 0", out_pc); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d expected 0", occupancy); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %0h expected 1", in_ready); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_discard: got %0h expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_stall_sat();
        logic [1:0] exp2[5];
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h20; in_instr = $urandom;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++; if (stall_cnt2 !== exp2[i]) $display("FAIL stall2_%0d: got %0d expected %0d", i, stall_cnt2, exp2[i]); else n_pass++;
            n_total++; if (stall_cnt !== 16'(i + 1)) $display("FAIL stall16_%0d: got %0d expected %0d", i, stall_cnt, i + 1); else n_pass++;
        end
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0;
        n_total++; if (stall_cnt !== 16'd5) $display("FAIL stall_flush_keep: got %0d expected 5", stall_cnt); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_instr  = $urandom;
            in_pc     = $urandom;
            step();
            n_total++; if (out_valid !== (q.size() > 0)) $display("FAIL rnd_valid c%0d: got %0h expected %0h", c, out_valid, q.size() > 0); else n_pass++;
            n_total++; if (out_pc !== exp_pc()) $display("FAIL rnd_pc c%0d: got %0h expected %0h", c, out_pc, exp_pc()); else n_pass++;
            n_total++; if (out_instr !== exp_instr()) $display("FAIL rnd_instr c%0d: got %0h expected %0h", c, out_instr, exp_instr()); else n_pass++;
            n_total++; if (occupancy !== 2'(q.size())) $display("FAIL rnd_occ c%0d: got %0d expected %0d", c, occupancy, q.size()); else n_pass++;
            n_total++; if (in_ready !== m_rdy) $display("FAIL rnd_in_ready c%0d: got %0h expected %0h", c, in_ready, m_rdy); else n_pass++;
            n_total++; if (stall_cnt !== 16'(m_stall16)) $display("FAIL rnd_stall16 c%0d: got %0d expected %0d", c, stall_cnt, m_stall16); else n_pass++;
            n_total++; if (stall_cnt2 !== 2'(m_stall2)) $display("FAIL rnd_stall2 c%0d: got %0d expected %0d", c, stall_cnt2, m_stall2); else n_pass++;
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h30; in_instr = $urandom;
        step();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL areset_pre_valid: got %0h expected 1", out_valid); else n_pass++;
        #2 reset = 1'b0;
        q.delete(); m_rdy = 1'b0; m_stall16 = 0; m_stall2 = 0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL areset_out_valid: got %0h expected 0", out_valid); else n_pass++;
        n_total++; if (occupancy !== 2'd0) $display("FAIL areset_occ: got %0d expected 0", occupancy); else n_pass++;
        n_total++; if (out_instr !== 32'h13) $display("FAIL areset_instr: got %0h expected 13", out_instr); else n_pass++;
        #1 reset = 1'b1;
        #0.5;
        n_total++; if (in_ready !== 1'b0) $display("FAIL areset_ready_pre_edge: got %0h expected 0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL areset_ready_post_edge: got %0h expected 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL areset_post_valid: got %0h expected 0", out_valid); else n_pass++;
        m_rdy = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_sat();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
